// File: rtl/mem_bridge_pkg.sv
// Shared types and constants for the core-to-bus memory bridge.
//   mem_size_t-style funct3 codes (RV32 load/store size/sign encoding)
//   bridge_state_t : bridge FSM states
package mem_bridge_pkg;

  localparam logic [2:0] MEM_B  = 3'd0;
  localparam logic [2:0] MEM_H  = 3'd1;
  localparam logic [2:0] MEM_W  = 3'd2;
  localparam logic [2:0] MEM_BU = 3'd4;
  localparam logic [2:0] MEM_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUS   = 2'd1,
    DONE  = 2'd2,
    FAULT = 2'd3
  } bridge_state_t;

endpackage

// File: rtl/mem_bridge_load_align.sv
// load_align: picks the addressed byte/halfword out of a bus word and
// sign- or zero-extends it according to the RV32 load funct3.
//   rdata    in  32  raw bus word
//   addr     in  2   byte offset within the word
//   funct3   in  3   load size/sign; unknown codes pass the full word
//   ext_data out 32  aligned, extended result
module load_align
  import mem_bridge_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] ext_data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = 8'h00;
    case (addr)
      2'd0: b = rdata[7:0];
      2'd1: b = rdata[15:8];
      2'd2: b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = addr[1] ? rdata[31:16] : rdata[15:0];

    case (funct3)
      MEM_B:   ext_data = {{24{b[7]}}, b};
      MEM_H:   ext_data = {{16{h[15]}}, h};
      MEM_BU:  ext_data = {24'h0, b};
      MEM_HU:  ext_data = {16'h0, h};
      default: ext_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_bridge.sv
// mem_bridge: converts the core's one-cycle mem_rden/mem_wren strobes into a
// valid/ready bus transaction, builds byte enables and lane-replicated store
// data, aligns/extends load data, and returns a one-cycle mem_done (with
// mem_fault on misalignment or bus timeout).
//   clk, rst                     clock, synchronous active-high reset
//   mem_rden/mem_wren            request strobes (both set = write)
//   mem_addr/mem_wdata/funct3    request address, store data, size/sign
//   mem_is_data                  0 = instruction fetch (forced word)
//   mem_rdata/mem_done/mem_fault completion back to the core
//   bus_*                        request side of the memory bus
module mem_bridge
  import mem_bridge_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_rden,
  input  logic              mem_wren,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic [2:0]        mem_funct3,
  input  logic              mem_is_data,
  output logic [31:0]       mem_rdata,
  output logic              mem_done,
  output logic              mem_fault,
  output logic              bus_valid,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  output logic [3:0]        bus_be,
  input  logic              bus_ready,
  input  logic [31:0]       bus_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  bridge_state_t    state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       lane_q;
  logic [2:0]       f3_q;

  logic        req;
  logic [2:0]  f3_eff;
  logic        misalign;
  logic [3:0]  be_nxt;
  logic [31:0] wdata_nxt;
  logic [31:0] ld_data;

  assign req    = mem_rden | mem_wren;
  // fetches always move a full word regardless of funct3
  assign f3_eff = mem_is_data ? mem_funct3 : MEM_W;

  // funct3[1:0]: 00 byte, 01 half, anything else is treated as word
  always_comb begin
    misalign  = 1'b0;
    be_nxt    = 4'b1111;
    wdata_nxt = mem_wdata;
    case (f3_eff[1:0])
      2'b00: begin
        be_nxt    = 4'b0001 << mem_addr[1:0];
        wdata_nxt = {4{mem_wdata[7:0]}};
      end
      2'b01: begin
        misalign  = mem_addr[0];
        be_nxt    = 4'b0011 << mem_addr[1:0];
        wdata_nxt = {2{mem_wdata[15:0]}};
      end
      default: misalign = |mem_addr[1:0];
    endcase
    if (!mem_wren) be_nxt = 4'b1111;
  end

  load_align u_load_align (
    .rdata    (bus_rdata),
    .addr     (lane_q),
    .funct3   (f3_q),
    .ext_data (ld_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      lane_q    <= 2'b00;
      f3_q      <= 3'b000;
      bus_valid <= 1'b0;
      bus_we    <= 1'b0;
      bus_be    <= 4'b0000;
      bus_addr  <= '0;
      bus_wdata <= 32'h0;
      mem_done  <= 1'b0;
      mem_fault <= 1'b0;
      mem_rdata <= 32'h0;
    end else begin
      mem_done  <= 1'b0;
      mem_fault <= 1'b0;
      case (state)
        IDLE: if (req) begin
          lane_q <= mem_addr[1:0];
          f3_q   <= f3_eff;
          if (misalign) begin
            // never touches the bus; report straight back to the core
            state     <= FAULT;
            mem_done  <= 1'b1;
            mem_fault <= 1'b1;
            mem_rdata <= 32'h0;
          end else begin
            state     <= BUS;
            cnt       <= '0;
            bus_valid <= 1'b1;
            bus_we    <= mem_wren;
            bus_addr  <= {mem_addr[ADDR_W-1:2], 2'b00};
            bus_be    <= be_nxt;
            if (mem_wren) bus_wdata <= wdata_nxt;
          end
        end
        BUS: begin
          if (bus_ready) begin
            bus_valid <= 1'b0;
            state     <= DONE;
            mem_done  <= 1'b1;
            if (!bus_we) mem_rdata <= ld_data;
          end else if (cnt == CNT_W'(TIMEOUT)) begin
            bus_valid <= 1'b0;
            state     <= FAULT;
            mem_done  <= 1'b1;
            mem_fault <= 1'b1;
            mem_rdata <= 32'h0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE:    state <= IDLE;
        FAULT:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bridge.sv
// Directed scoreboard bench for mem_bridge. Stimulus pushes expected bus
// requests and core responses into queues; a negedge monitor pops and checks.
module tb_mem_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_rden = 1'b0, mem_wren = 1'b0;
  logic [31:0] mem_addr = 32'h0, mem_wdata = 32'h0;
  logic [2:0]  mem_funct3 = 3'd0;
  logic        mem_is_data = 1'b1;
  logic [31:0] mem_rdata;
  logic        mem_done, mem_fault;
  logic        bus_valid, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ready = 1'b0;
  logic [31:0] bus_rdata = 32'h0;

  always #5 clk = ~clk;

  mem_bridge #(.ADDR_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .mem_rden(mem_rden), .mem_wren(mem_wren), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_funct3(mem_funct3), .mem_is_data(mem_is_data),
    .mem_rdata(mem_rdata), .mem_done(mem_done), .mem_fault(mem_fault),
    .bus_valid(bus_valid), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_be(bus_be),
    .bus_ready(bus_ready), .bus_rdata(bus_rdata)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        chk_wd;
  } bus_exp_t;

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
  } resp_t;

  bus_exp_t bus_q[$];
  resp_t    resp_q[$];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic exp_bus(input logic we, input logic [31:0] a, input logic [3:0] be,
                         input logic [31:0] wd);
    bus_exp_t e;
    e.we = we; e.addr = a; e.be = be; e.wdata = wd; e.chk_wd = we;
    bus_q.push_back(e);
  endtask

  task automatic exp_resp(input logic [31:0] rd, input logic f);
    resp_t r;
    r.rdata = rd; r.fault = f;
    resp_q.push_back(r);
  endtask

  // Issue one strobe, play the slave (ready after 'waits' valid cycles,
  // never if waits < 0) and check the completion latency.
  task automatic txn(input logic rd, input logic wr, input logic [31:0] a,
                     input logic [31:0] wd, input logic [2:0] f3, input logic isd,
                     input logic [31:0] rdat, input int waits, input int exp_lat,
                     output int vcnt);
    bit done;
    @(posedge clk); #1;
    mem_rden = rd; mem_wren = wr; mem_addr = a; mem_wdata = wd;
    mem_funct3 = f3; mem_is_data = isd; bus_rdata = rdat; bus_ready = 1'b0;
    vcnt = 0; done = 0;
    for (int i = 1; i <= 40 && !done; i++) begin
      @(posedge clk); #1;
      mem_rden = 1'b0; mem_wren = 1'b0;
      if (mem_done) begin
        done = 1;
        chk("done_latency", i, exp_lat);
      end else if (bus_valid) begin
        bus_ready = (vcnt == waits);
        vcnt++;
      end else begin
        bus_ready = 1'b0;
      end
    end
    if (!done) chk("done_wait_expired", 32'd0, 32'd1);
    bus_ready = 1'b0;
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (bus_q.size() == 0) begin
        chk("bus_valid_idle", {31'b0, bus_valid}, 32'd0);
      end else if (bus_valid && bus_ready) begin
        bus_exp_t e;
        e = bus_q.pop_front();
        chk("bus_we", {31'b0, bus_we}, {31'b0, e.we});
        chk("bus_addr", bus_addr, e.addr);
        chk("bus_be", {28'b0, bus_be}, {28'b0, e.be});
        if (e.chk_wd) chk("bus_wdata", bus_wdata, e.wdata);
      end
      if (mem_done) begin
        if (resp_q.size() == 0) begin
          chk("unexpected_mem_done", 32'd1, 32'd0);
        end else begin
          resp_t r;
          r = resp_q.pop_front();
          chk("mem_rdata", mem_rdata, r.rdata);
          chk("mem_fault", {31'b0, mem_fault}, {31'b0, r.fault});
        end
      end else if (mem_fault) begin
        chk("fault_without_done", 32'd1, 32'd0);
      end
    end
  end

  initial begin
    int vc;
    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bus_valid", {31'b0, bus_valid}, 32'd0);
    chk("rst_bus_we",    {31'b0, bus_we}, 32'd0);
    chk("rst_bus_be",    {28'b0, bus_be}, 32'd0);
    chk("rst_bus_addr",  bus_addr, 32'd0);
    chk("rst_bus_wdata", bus_wdata, 32'd0);
    chk("rst_mem_done",  {31'b0, mem_done}, 32'd0);
    chk("rst_mem_fault", {31'b0, mem_fault}, 32'd0);
    chk("rst_mem_rdata", mem_rdata, 32'd0);
    rst = 1'b0;

    // LW zero wait
    exp_bus(0, 32'h100, 4'hF, 32'h0); exp_resp(32'hDEADBEEF, 0);
    txn(1, 0, 32'h100, 32'h0, 3'd2, 1, 32'hDEADBEEF, 0, 2, vc);
    // LB / LBU with 3 wait cycles
    exp_bus(0, 32'h100, 4'hF, 32'h0); exp_resp(32'hFFFFFF80, 0);
    txn(1, 0, 32'h103, 32'h0, 3'd0, 1, 32'h80112233, 3, 5, vc);
    exp_bus(0, 32'h100, 4'hF, 32'h0); exp_resp(32'h00000080, 0);
    txn(1, 0, 32'h103, 32'h0, 3'd4, 1, 32'h80112233, 3, 5, vc);
    // SH upper half, one wait; rdata holds previous load
    exp_bus(1, 32'h100, 4'b1100, 32'hABCDABCD); exp_resp(32'h00000080, 0);
    txn(0, 1, 32'h102, 32'h1234ABCD, 3'd1, 1, 32'h0, 1, 3, vc);
    // misaligned LW and SH: immediate fault, no bus traffic
    exp_resp(32'h0, 1);
    txn(1, 0, 32'h101, 32'h0, 3'd2, 1, 32'h0, 0, 1, vc);
    exp_resp(32'h0, 1);
    txn(0, 1, 32'h203, 32'h5555, 3'd1, 1, 32'h0, 0, 1, vc);
    // LH upper sign-extended, LHU lower zero-extended
    exp_bus(0, 32'h100, 4'hF, 32'h0); exp_resp(32'hFFFF8001, 0);
    txn(1, 0, 32'h102, 32'h0, 3'd1, 1, 32'h80015555, 2, 4, vc);
    exp_bus(0, 32'h100, 4'hF, 32'h0); exp_resp(32'h0000F00D, 0);
    txn(1, 0, 32'h100, 32'h0, 3'd5, 1, 32'h1234F00D, 0, 2, vc);
    // SB lane 1, SW
    exp_bus(1, 32'h100, 4'b0010, 32'hA5A5A5A5); exp_resp(32'h0000F00D, 0);
    txn(0, 1, 32'h101, 32'h000000A5, 3'd0, 1, 32'h0, 0, 2, vc);
    exp_bus(1, 32'h204, 4'hF, 32'h11223344); exp_resp(32'h0000F00D, 0);
    txn(0, 1, 32'h204, 32'h11223344, 3'd2, 1, 32'h0, 0, 2, vc);
    // fetch with a byte funct3 still moves a full word
    exp_bus(0, 32'h108, 4'hF, 32'h0); exp_resp(32'hCAFEF00D, 0);
    txn(1, 0, 32'h108, 32'h0, 3'd0, 0, 32'hCAFEF00D, 0, 2, vc);
    // both strobes: write wins
    exp_bus(1, 32'h10C, 4'hF, 32'h55AA55AA); exp_resp(32'hCAFEF00D, 0);
    txn(1, 1, 32'h10C, 32'h55AA55AA, 3'd2, 1, 32'h12345678, 0, 2, vc);
    // timeout: 5 valid cycles then fault
    exp_bus(0, 32'h110, 4'hF, 32'h0); exp_resp(32'h0, 1);
    txn(1, 0, 32'h110, 32'h0, 3'd2, 1, 32'h0, -1, 6, vc);
    chk("timeout_valid_cycles", vc, 32'd5);
    bus_q.delete();
    exp_bus(0, 32'h114, 4'hF, 32'h0); exp_resp(32'h0BADF00D, 0);
    txn(1, 0, 32'h114, 32'h0, 3'd2, 1, 32'h0BADF00D, 0, 2, vc);

    // reset while waiting on the bus
    exp_bus(0, 32'h120, 4'hF, 32'h0);
    @(posedge clk); #1;
    mem_rden = 1'b1; mem_addr = 32'h120; mem_funct3 = 3'd2; mem_is_data = 1'b1;
    bus_ready = 1'b0;
    @(posedge clk); #1;
    mem_rden = 1'b0;
    chk("pre_rst_valid", {31'b0, bus_valid}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_valid", {31'b0, bus_valid}, 32'd0);
    chk("mid_rst_done",  {31'b0, mem_done}, 32'd0);
    chk("mid_rst_rdata", mem_rdata, 32'd0);
    chk("mid_rst_addr",  bus_addr, 32'd0);
    bus_q.delete();
    rst = 1'b0;
    exp_bus(0, 32'h118, 4'hF, 32'h0); exp_resp(32'h13579BDF, 0);
    txn(1, 0, 32'h118, 32'h0, 3'd2, 1, 32'h13579BDF, 0, 2, vc);

    repeat (3) @(posedge clk);
    chk("resp_q_drained", resp_q.size(), 32'd0);
    chk("bus_q_drained", bus_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
